// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns engine.
// A 128-bit state is captured over a valid/ready handshake, one column is
// inverse-mixed per cycle over GF(2^8), and the result is held on a second
// valid/ready handshake until the downstream stage takes it.
// Byte (row r, col c) lives at state[127-8*(4c+r) -: 8] (column-major).

module inv_mix_columns_seq (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_r;
   logic [1:0]     col_r;
   logic [127:0]   work_r;
   logic           in_ready_r;
   logic           out_valid_r;

   logic [31:0]    col_in_s;
   logic [31:0]    col_out_s;
   logic [127:0]   work_next_s;

   // Multiply by x in GF(2^8) with reduction polynomial 0x11b.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // Inverse-mix one column; a0 is the most significant byte (row 0).
   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a  [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] b  [4];
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2[i] = xtime(a[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
         m9[i] = x8[i] ^ a[i];
         mb[i] = x8[i] ^ x2[i] ^ a[i];
         md[i] = x8[i] ^ x4[i] ^ a[i];
         me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      b[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      b[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      b[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      b[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      return {b[0], b[1], b[2], b[3]};
   endfunction

   // Select the column addressed by col_r, transform it and splice it back.
   always_comb begin
      col_in_s    = 32'h0000_0000;
      work_next_s = work_r;
      case (col_r)
         2'd0:    col_in_s = work_r[127:96];
         2'd1:    col_in_s = work_r[95:64];
         2'd2:    col_in_s = work_r[63:32];
         2'd3:    col_in_s = work_r[31:0];
         default: col_in_s = 32'h0000_0000;
      endcase
      col_out_s = inv_mix_col(col_in_s);
      case (col_r)
         2'd0:    work_next_s[127:96] = col_out_s;
         2'd1:    work_next_s[95:64]  = col_out_s;
         2'd2:    work_next_s[63:32]  = col_out_s;
         2'd3:    work_next_s[31:0]   = col_out_s;
         default: work_next_s         = work_r;
      endcase
   end

   // Control FSM with registered handshake outputs and the working register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         col_r       <= 2'd0;
         work_r      <= 128'h0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  work_r      <= in_state;
                  col_r       <= 2'd0;
                  state_r     <= BUSY;
                  in_ready_r  <= 1'b0;
               end
            end
            BUSY: begin
               work_r <= work_next_s;
               col_r  <= col_r + 2'd1;
               if (col_r == 2'd3) begin
                  state_r     <= DONE;
                  out_valid_r <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_r     <= IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               col_r       <= 2'd0;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_state = work_r;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: directed FIPS-197 vectors,
// backpressure, asynchronous mid-operation reset and a randomized round trip
// through a forward-MixColumns reference model.

module tb_inv_mix_columns_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;

   int total = 0;
   int bad   = 0;

   inv_mix_columns_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state)
   );

   always #5 clk = ~clk;

   // Generic shift-and-add GF(2^8) multiply, polynomial 0x11b.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      end
      return p;
   endfunction

   // Circulant matrix multiply of every column; inv selects the matrix.
   function automatic logic [127:0] mix_state(input logic [127:0] st, input bit inv);
      logic [7:0] coef [4];
      logic [127:0] res = 128'h0;
      logic [7:0] acc;
      if (inv) begin
         coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
      end else begin
         coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(coef[(j - r + 4) % 4], st[127-8*(4*c+j) -: 8]);
            res[127-8*(4*c+r) -: 8] = acc;
         end
      end
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Push one state, wait for the result, check latency, value and handshake.
   task automatic run_vec(input logic [127:0] st, input logic [127:0] exp,
                          input string tag, input bit rnd);
      int n;
      bit hs;
      in_valid = 1'b1;
      in_state = st;
      n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      check({tag, "_ready"}, {127'h0, in_ready}, 128'h1);
      step();
      in_valid = 1'b0;
      in_state = rand128();
      n = 0;
      while (!out_valid && n < 20) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      check({tag, "_lat"}, 128'(n), 128'd4);
      check({tag, "_data"}, out_state, exp);
      hs = 1'b0;
      n = 0;
      while (!hs && n < 50) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         hs = out_ready;
         step();
         n++;
      end
      check({tag, "_hs"}, {126'h0, hs, in_ready & ~out_valid}, 128'h3);
      out_ready = 1'b0;
   endtask

   logic [127:0] v, d;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_state  = 128'h0;
      out_ready = 1'b0;
      #12;
      check("rst_state", {out_valid, in_ready, out_state}, {1'b0, 1'b1, 128'h0});
      rst = 1'b0;
      #4;

      // Single column vector.
      run_vec({32'h8e4da1bc, 96'h0}, {32'hdb135345, 96'h0}, "col0", 1'b0);
      // Full FIPS-197 state.
      run_vec(128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8,
              128'hdb135345_f20a225c_d4d4d4d5_2d26314c, "fips", 1'b0);
      // Fixed points.
      run_vec({4{32'h01010101}}, {4{32'h01010101}}, "fix01", 1'b0);
      run_vec({4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}}, "fixc6", 1'b0);

      // Backpressure: hold the result for 10 cycles while new data is offered.
      v = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
      in_valid = 1'b1;
      in_state = v;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 20 && !out_valid; i++) step();
      check("bp_valid", {127'h0, out_valid}, 128'h1);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_state = rand128();
         step();
         check("bp_hold", out_state, 128'hdb135345_f20a225c_d4d4d4d5_2d26314c);
         check("bp_flags", {126'h0, out_valid, in_ready}, 128'h2);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_release", {126'h0, out_valid, in_ready}, 128'h1);
      check("bp_result", out_state, 128'hdb135345_f20a225c_d4d4d4d5_2d26314c);

      // Asynchronous reset while column 2 is next to be processed.
      in_valid = 1'b1;
      in_state = rand128();
      step();
      in_valid = 1'b0;
      step();
      step();
      #2 rst = 1'b1;
      #1;
      check("mid_rst", {out_valid, in_ready, out_state}, {1'b0, 1'b1, 128'h0});
      #1 rst = 1'b0;
      step();
      check("post_rst_idle", {126'h0, out_valid, in_ready}, 128'h1);
      d = rand128();
      run_vec(mix_state(d, 1'b0), d, "post_rst", 1'b0);

      // Randomized round trip through forward MixColumns.
      for (int i = 0; i < 1000; i++) begin
         d = rand128();
         v = mix_state(d, 1'b0);
         run_vec(v, d, "rand", 1'b1);
      end
      // Cross-check the model itself against the inverse direction once.
      check("model_inv", mix_state(v, 1'b1), d);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
